// File: rtl/washer_plant.sv
// -----------------------------------------------------------------------------
// washer_plant
//
// Behavioural model of a washing-machine drum. It covers the water level, the
// heater, the wash motor and the dryer. It takes the controller's actuator
// commands and returns the sensor feedback that a real appliance would give.
// Use it for closed-loop simulation and on demo boards that have no appliance.
//
// Ports
//   inpFreq      in   clock, every state update happens on the rising edge
//   rst          in   synchronous active-high reset
//   fill         in   fill valve command
//   warm         in   heater command
//   wash         in   motor command
//   drain        in   drain pump command
//   dry          in   dryer command
//   faucet       in   1 = mains water available
//   door         in   1 = door open
//   level        out  water level, 0..LEVEL_MAX
//   temp         out  water temperature, 0..TEMP_MAX
//   water_full   out  level == LEVEL_MAX
//   water_empty  out  level == 0
//   temp_ok      out  temp >= TEMP_TARGET
//   wash_done    out  wash timer reached WASH_CYCLES
//   dry_done     out  dry timer reached DRY_CYCLES
//   door_locked  out  drum busy, holding water, or faulted
//   fault        out  sticky fault flag (cleared only by rst)
//   phase        out  0 IDLE, 1 FILL, 2 HEAT, 3 WASH, 4 DRAIN, 5 DRY, 7 FAULT
//
// The phase output is the FSM state register itself, so it doubles as the
// debug view of the state machine.
//
// Command handshake: the commands are level-sensitive. There is no valid/ready
// pairing. The plant samples each command on every rising edge, and it
// reports progress only through the level-type status outputs above. None of
// the outputs is a pulse.
// -----------------------------------------------------------------------------
module washer_plant #(
    parameter int LEVEL_MAX   = 8,
    parameter int TEMP_TARGET = 6,
    parameter int TEMP_MAX    = 10,
    parameter int COOL_DIV    = 4,
    parameter int WASH_CYCLES = 12,
    parameter int DRY_CYCLES  = 8
) (
    input  logic       inpFreq,
    input  logic       rst,
    input  logic       fill,
    input  logic       warm,
    input  logic       wash,
    input  logic       drain,
    input  logic       dry,
    input  logic       faucet,
    input  logic       door,
    output logic [3:0] level,
    output logic [3:0] temp,
    output logic       water_full,
    output logic       water_empty,
    output logic       temp_ok,
    output logic       wash_done,
    output logic       dry_done,
    output logic       door_locked,
    output logic       fault,
    output logic [2:0] phase
);

    // Counter widths, sized so that each counter reaches its limit with no wrap.
    localparam int WASH_W = $clog2(WASH_CYCLES + 1);
    localparam int DRY_W  = $clog2(DRY_CYCLES + 1);
    localparam int COOL_W = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;

    localparam logic [3:0]        LEVEL_FULL = 4'(LEVEL_MAX);
    localparam logic [3:0]        TEMP_HOT   = 4'(TEMP_MAX);
    localparam logic [3:0]        TEMP_GOOD  = 4'(TEMP_TARGET);
    localparam logic [WASH_W-1:0] WASH_END   = WASH_W'(WASH_CYCLES);
    localparam logic [DRY_W-1:0]  DRY_END    = DRY_W'(DRY_CYCLES);
    localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(COOL_DIV - 1);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_HEAT  = 3'd2,
        PH_WASH  = 3'd3,
        PH_DRAIN = 3'd4,
        PH_DRY   = 3'd5,
        PH_FAULT = 3'd7
    } phase_t;

    phase_t state;
    phase_t state_next;

    logic [3:0]        level_q, level_next;
    logic [3:0]        temp_q, temp_next;
    logic [COOL_W-1:0] cool_q, cool_next;
    logic [WASH_W-1:0] wash_q, wash_next;
    logic [DRY_W-1:0]  dry_q, dry_next;

    logic any_cmd;
    logic fault_cond;
    logic frozen;

    // -------------------------------------------------------------------------
    // Fault detection. It uses the registered level, so "warm into an empty
    // drum" is judged against the water present before this edge.
    // -------------------------------------------------------------------------
    always_comb begin
        any_cmd    = fill | warm | wash | drain | dry;
        fault_cond = (fill & drain)
                   | (warm & (level_q == 4'd0))
                   | (door & any_cmd);
        // The fault check takes precedence over every update. It blocks the
        // update on the edge that detects the fault, and it holds everything
        // afterwards while the state stays in FAULT.
        frozen     = (state == PH_FAULT) | fault_cond;
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge inpFreq) begin
        if (rst) begin
            state <= PH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next state. FAULT is absorbing. Otherwise the next state
    // is the highest-priority active command, which makes phase lag the
    // commands by one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (state != PH_FAULT) begin
            if (fault_cond) begin
                state_next = PH_FAULT;
            end else if (fill) begin
                state_next = PH_FILL;
            end else if (warm) begin
                state_next = PH_HEAT;
            end else if (wash) begin
                state_next = PH_WASH;
            end else if (drain) begin
                state_next = PH_DRAIN;
            end else if (dry) begin
                state_next = PH_DRY;
            end else begin
                state_next = PH_IDLE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs derived from the state and the registered data
    // -------------------------------------------------------------------------
    always_comb begin
        phase       = state;
        fault       = (state == PH_FAULT);
        level       = level_q;
        temp        = temp_q;
        water_full  = (level_q == LEVEL_FULL);
        water_empty = (level_q == 4'd0);
        temp_ok     = (temp_q >= TEMP_GOOD);
        wash_done   = (wash_q == WASH_END);
        dry_done    = (dry_q == DRY_END);
        door_locked = any_cmd | (level_q != 4'd0) | (state == PH_FAULT);
    end

    // -------------------------------------------------------------------------
    // Water level. fill and drain never act together, because that combination
    // is a fault and freezes the drum.
    // -------------------------------------------------------------------------
    always_comb begin
        level_next = level_q;
        if (!frozen) begin
            if (fill && faucet) begin
                if (level_q != LEVEL_FULL) begin
                    level_next = level_q + 4'd1;
                end
            end else if (drain) begin
                if (level_q != 4'd0) begin
                    level_next = level_q - 4'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Temperature. With the heater off, the water cools one step every
    // COOL_DIV cycles. Heating restarts the cooling prescaler so that each
    // cool-down interval is a full one. When the drum drains empty, the
    // temperature drops straight to 0, because no water remains to hold heat.
    // -------------------------------------------------------------------------
    always_comb begin
        temp_next = temp_q;
        cool_next = cool_q;
        if (!frozen) begin
            if (warm) begin
                // A non-empty drum is guaranteed here, since warm with an
                // empty drum is a fault.
                if (temp_q != TEMP_HOT) begin
                    temp_next = temp_q + 4'd1;
                end
                cool_next = '0;
            end else if (temp_q != 4'd0) begin
                if (cool_q == COOL_LAST) begin
                    cool_next = '0;
                    temp_next = temp_q - 4'd1;
                end else begin
                    cool_next = cool_q + 1'b1;
                end
            end else begin
                cool_next = '0;
            end

            if ((level_q != 4'd0) && (level_next == 4'd0)) begin
                temp_next = 4'd0;
                cool_next = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Wash and dry timers. A timer counts only under its drum condition, holds
    // while its command is high but the condition is not met, and clears as
    // soon as its command drops.
    // -------------------------------------------------------------------------
    always_comb begin
        wash_next = wash_q;
        dry_next  = dry_q;
        if (!frozen) begin
            if (!wash) begin
                wash_next = '0;
            end else if ((level_q == LEVEL_FULL) && (wash_q != WASH_END)) begin
                wash_next = wash_q + 1'b1;
            end

            if (!dry) begin
                dry_next = '0;
            end else if ((level_q == 4'd0) && (dry_q != DRY_END)) begin
                dry_next = dry_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge inpFreq) begin
        if (rst) begin
            level_q <= 4'd0;
            temp_q  <= 4'd0;
            cool_q  <= '0;
            wash_q  <= '0;
            dry_q   <= '0;
        end else begin
            level_q <= level_next;
            temp_q  <= temp_next;
            cool_q  <= cool_next;
            wash_q  <= wash_next;
            dry_q   <= dry_next;
        end
    end

endmodule

// File: tb/tb_washer_plant.sv
// -----------------------------------------------------------------------------
// tb_washer_plant
//
// Directed bench for washer_plant. Before each step the expected values are
// pushed onto exp_q. After the clock edge they are popped and compared with
// the outputs sampled 1 ns past the rising edge.
// -----------------------------------------------------------------------------
module tb_washer_plant;

    // ---------------- clock / reset ----------------
    logic inpFreq = 1'b0;
    always #5 inpFreq = ~inpFreq;

    logic       rst    = 1'b1;
    logic       fill   = 1'b0;
    logic       warm   = 1'b0;
    logic       wash   = 1'b0;
    logic       drain  = 1'b0;
    logic       dry    = 1'b0;
    logic       faucet = 1'b0;
    logic       door   = 1'b0;
    logic [3:0] level;
    logic [3:0] temp;
    logic       water_full, water_empty, temp_ok, wash_done, dry_done;
    logic       door_locked, fault;
    logic [2:0] phase;

    washer_plant dut (
        .inpFreq     (inpFreq),
        .rst         (rst),
        .fill        (fill),
        .warm        (warm),
        .wash        (wash),
        .drain       (drain),
        .dry         (dry),
        .faucet      (faucet),
        .door        (door),
        .level       (level),
        .temp        (temp),
        .water_full  (water_full),
        .water_empty (water_empty),
        .temp_ok     (temp_ok),
        .wash_done   (wash_done),
        .dry_done    (dry_done),
        .door_locked (door_locked),
        .fault       (fault),
        .phase       (phase)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic expect_v(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty observed=%0d", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge inpFreq);
        #1;
    endtask

    task automatic cmds(input logic f, input logic w, input logic ws,
                        input logic d, input logic dr);
        fill  = f;
        warm  = w;
        wash  = ws;
        drain = d;
        dry   = dr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        expect_v(0); expect_v(0); expect_v(1); expect_v(0); expect_v(0);
        expect_v(0); expect_v(0); expect_v(0); expect_v(0); expect_v(0);
        tick();
        chk("rst_level", 16'(level));
        chk("rst_temp", 16'(temp));
        chk("rst_empty", 16'(water_empty));
        chk("rst_full", 16'(water_full));
        chk("rst_temp_ok", 16'(temp_ok));
        chk("rst_wash_done", 16'(wash_done));
        chk("rst_dry_done", 16'(dry_done));
        chk("rst_door_locked", 16'(door_locked));
        chk("rst_fault", 16'(fault));
        chk("rst_phase", 16'(phase));

        // Fill from empty: level 1..8, full on the 8th edge, empty falls on the 1st edge
        rst = 1'b0;
        faucet = 1'b1;
        cmds(1, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            expect_v(16'(i));
            expect_v(0);
            expect_v(16'(i == 8));
            tick();
            chk("fill_level", 16'(level));
            chk("fill_empty", 16'(water_empty));
            chk("fill_full", 16'(water_full));
        end
        for (int i = 0; i < 3; i++) begin
            expect_v(8);
            tick();
            chk("fill_sat_level", 16'(level));
        end
        expect_v(1); expect_v(1);
        chk("fill_phase", 16'(phase));
        chk("fill_door_locked", 16'(door_locked));

        // Heat a full drum for 6 cycles
        cmds(0, 1, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            expect_v(16'(i));
            tick();
            chk("heat_temp", 16'(temp));
        end
        expect_v(1); expect_v(2);
        chk("heat_temp_ok", 16'(temp_ok));
        chk("heat_phase", 16'(phase));

        // Cool down: one step after 4 cycles
        cmds(0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            expect_v((i < 4) ? 16'd6 : 16'd5);
            tick();
            chk("cool_temp", 16'(temp));
        end

        // Wash a full drum: done after exactly 12 edges
        cmds(0, 0, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            expect_v(16'(i == 12));
            tick();
            chk("wash_done_count", 16'(wash_done));
        end
        expect_v(3);
        chk("wash_phase", 16'(phase));
        expect_v(1);
        tick();
        chk("wash_done_hold", 16'(wash_done));
        wash = 1'b0;
        expect_v(0);
        tick();
        chk("wash_done_clear", 16'(wash_done));
        wash = 1'b1;
        expect_v(0);
        tick();
        chk("wash_restart", 16'(wash_done));

        // Drain 8 cycles from full
        cmds(0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            expect_v(16'(8 - i));
            tick();
            chk("drain_level", 16'(level));
        end
        expect_v(0); expect_v(1); expect_v(4);
        chk("drain_temp", 16'(temp));
        chk("drain_empty", 16'(water_empty));
        chk("drain_phase", 16'(phase));

        // Dry an empty drum: done after 8 edges
        cmds(0, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            expect_v(16'(i == 8));
            tick();
            chk("dry_done_count", 16'(dry_done));
        end
        expect_v(1);
        chk("dry_door_locked", 16'(door_locked));
        cmds(0, 0, 0, 0, 0);
        #1;
        expect_v(0);
        chk("idle_door_unlocked", 16'(door_locked));
        expect_v(0); expect_v(0);
        tick();
        chk("idle_phase", 16'(phase));
        chk("idle_dry_done", 16'(dry_done));

        // Fault: fill + drain at level 3 freezes the drum
        do_reset();
        cmds(1, 0, 0, 0, 0);
        repeat (3) tick();
        expect_v(3);
        chk("pre_fault_level", 16'(level));
        cmds(1, 0, 0, 1, 0);
        expect_v(7); expect_v(1); expect_v(3);
        tick();
        chk("fault_phase", 16'(phase));
        chk("fault_flag", 16'(fault));
        chk("fault_level", 16'(level));
        cmds(1, 0, 0, 0, 0);
        repeat (3) tick();
        expect_v(3); expect_v(7); expect_v(1);
        chk("fault_frozen_level", 16'(level));
        chk("fault_frozen_phase", 16'(phase));
        chk("fault_sticky", 16'(fault));
        cmds(0, 0, 0, 0, 0);
        #1;
        expect_v(1);
        chk("fault_door_locked", 16'(door_locked));
        expect_v(0); expect_v(0); expect_v(0); expect_v(1); expect_v(0);
        rst = 1'b1;
        tick();
        chk("fault_rst_level", 16'(level));
        chk("fault_rst_flag", 16'(fault));
        chk("fault_rst_phase", 16'(phase));
        chk("fault_rst_empty", 16'(water_empty));
        chk("fault_rst_door", 16'(door_locked));
        rst = 1'b0;

        // Fault: warm into an empty drum
        cmds(0, 1, 0, 0, 0);
        expect_v(1); expect_v(7); expect_v(0);
        tick();
        chk("warm_empty_fault", 16'(fault));
        chk("warm_empty_phase", 16'(phase));
        chk("warm_empty_temp", 16'(temp));
        cmds(0, 0, 0, 0, 0);
        do_reset();

        // Fill with no mains water: level holds, no fault
        faucet = 1'b0;
        cmds(1, 0, 0, 0, 0);
        repeat (5) tick();
        expect_v(0); expect_v(0); expect_v(1);
        chk("nofaucet_level", 16'(level));
        chk("nofaucet_fault", 16'(fault));
        chk("nofaucet_phase", 16'(phase));

        // Reset mid-fill at level 4
        faucet = 1'b1;
        repeat (4) tick();
        expect_v(4);
        chk("midfill_level", 16'(level));
        rst = 1'b1;
        expect_v(0); expect_v(0);
        tick();
        chk("midfill_rst_level", 16'(level));
        chk("midfill_rst_phase", 16'(phase));
        rst = 1'b0;
        cmds(0, 0, 0, 0, 0);
        tick();

        // Draining to empty forces the temperature to 0
        cmds(1, 0, 0, 0, 0);
        repeat (2) tick();
        cmds(0, 1, 0, 0, 0);
        repeat (5) tick();
        expect_v(5);
        chk("warm_partial_temp", 16'(temp));
        cmds(0, 0, 0, 1, 0);
        expect_v(1); expect_v(5);
        tick();
        chk("drain1_level", 16'(level));
        chk("drain1_temp", 16'(temp));
        expect_v(0); expect_v(0);
        tick();
        chk("drain0_level", 16'(level));
        chk("drain0_temp_forced", 16'(temp));
        expect_v(0); expect_v(0);
        tick();
        chk("drain_sat_level", 16'(level));
        chk("drain_sat_fault", 16'(fault));
        cmds(0, 0, 0, 0, 0);

        // Door open: harmless while idle, a fault with any command
        door = 1'b1;
        expect_v(0);
        tick();
        chk("door_idle_fault", 16'(fault));
        cmds(0, 0, 1, 0, 0);
        expect_v(1); expect_v(7);
        tick();
        chk("door_cmd_fault", 16'(fault));
        chk("door_cmd_phase", 16'(phase));
        cmds(0, 0, 0, 0, 0);
        door = 1'b0;
        do_reset();

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
